// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - segment patterns, error codes and receiver FSM encoding
package sevenseg_pkg;

  // Active-high gfedcba patterns shared with the display-side encoder.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_BAD_PATTERN = 2'd1;
  localparam logic [1:0] ERR_SYNC        = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW    = 2'd3;

  localparam logic [9:0] VALUE_MAX = 10'd255;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_DIG_H,
    ST_DIG_T,
    ST_DIG_O,
    ST_WAIT_BLANK
  } state_t;

endpackage

// File: rtl/sevenseg_pattern_decoder.sv
// rtl/sevenseg_pattern_decoder.sv - maps a segment pattern to a BCD digit or blank
module sevenseg_pattern_decoder
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       is_digit,
  output logic       is_blank
);

  always_comb begin
    digit    = 4'd0;
    is_digit = 1'b1;
    is_blank = 1'b0;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_stream_receiver.sv
// rtl/sevenseg_stream_receiver.sv - reassembles hundreds/tens/ones frames from a strobed segment bus
module sevenseg_stream_receiver
  import sevenseg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic       strobe,
  output logic [7:0] value,
  output logic       frame_valid,
  output logic       err,
  output logic [1:0] err_code,
  output logic       locked
);

  logic [3:0] digit;
  logic       is_digit;
  logic       is_blank;
  logic [9:0] acc;
  logic [9:0] sum;
  state_t     state;

  sevenseg_pattern_decoder u_decoder (
    .seg      (seg),
    .digit    (digit),
    .is_digit (is_digit),
    .is_blank (is_blank)
  );

  // acc never exceeds 99 when a digit is appended, so the sum fits in 10 bits.
  assign sum = acc * 10'd10 + 10'(digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_HUNT;
      acc         <= 10'd0;
      value       <= 8'd0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
      locked      <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      err         <= 1'b0;
      if (strobe) begin
        case (state)
          ST_HUNT: begin
            if (is_blank) begin
              state  <= ST_DIG_H;
              acc    <= 10'd0;
              locked <= 1'b1;
            end
          end
          ST_DIG_H, ST_DIG_T, ST_DIG_O: begin
            if (is_digit) begin
              acc <= sum;
              if (state == ST_DIG_H) begin
                state <= ST_DIG_T;
              end else if (state == ST_DIG_T) begin
                state <= ST_DIG_O;
              end else begin
                state <= ST_WAIT_BLANK;
                if (sum > VALUE_MAX) begin
                  err      <= 1'b1;
                  err_code <= ERR_OVERFLOW;
                end else begin
                  value       <= sum[7:0];
                  frame_valid <= 1'b1;
                end
              end
            end else if (is_blank) begin
              // An early blank is taken as the start of a fresh frame.
              state    <= ST_DIG_H;
              acc      <= 10'd0;
              err      <= 1'b1;
              err_code <= ERR_SYNC;
            end else begin
              state    <= ST_HUNT;
              locked   <= 1'b0;
              err      <= 1'b1;
              err_code <= ERR_BAD_PATTERN;
            end
          end
          ST_WAIT_BLANK: begin
            if (is_blank) begin
              state <= ST_DIG_H;
              acc   <= 10'd0;
            end else begin
              state    <= ST_HUNT;
              locked   <= 1'b0;
              err      <= 1'b1;
              err_code <= ERR_SYNC;
            end
          end
          default: begin
            state  <= ST_HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_stream_receiver.sv
// tb/tb_sevenseg_stream_receiver.sv - randomized self-checking bench with a frame-level reference model
module tb_sevenseg_stream_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg;
  logic       strobe;
  logic [7:0] value;
  logic       frame_valid;
  logic       err;
  logic [1:0] err_code;
  logic       locked;

  int checks = 0;
  int failures = 0;

  sevenseg_stream_receiver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .strobe      (strobe),
    .value       (value),
    .frame_valid (frame_valid),
    .err         (err),
    .err_code    (err_code),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  logic [6:0] pat [0:10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                             7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h00};
  localparam logic [6:0] BLANK = 7'h00;

  // Reference model: since the last accepted delimiter, keep the digits seen so far.
  bit         m_synced;
  int         m_digits[$];
  logic [7:0] m_value;
  logic       m_fv;
  logic       m_err;
  logic [1:0] m_code;

  function automatic int classify(input logic [6:0] p);
    for (int i = 0; i <= 10; i++)
      if (pat[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [12:0] obs();
    return {value, frame_valid, err, err_code, locked};
  endfunction

  function automatic logic [12:0] expv();
    return {m_value, m_fv, m_err, m_code, logic'(m_synced)};
  endfunction

  task automatic model_reset();
    m_synced = 0;
    m_digits.delete();
    m_value = 8'd0;
    m_fv = 0;
    m_err = 0;
    m_code = 2'd0;
  endtask

  task automatic model_error(input logic [1:0] code);
    m_err = 1;
    m_code = code;
  endtask

  task automatic model_slot(input logic [6:0] p);
    int d;
    int n;
    d = classify(p);
    m_fv = 0;
    m_err = 0;
    if (!m_synced) begin
      if (d == 10) begin
        m_synced = 1;
        m_digits.delete();
      end
    end else if (m_digits.size() == 3) begin
      if (d == 10) m_digits.delete();
      else begin
        model_error(2'd2);
        m_synced = 0;
      end
    end else if (d == 10) begin
      model_error(2'd2);
      m_digits.delete();
    end else if (d < 0) begin
      model_error(2'd1);
      m_synced = 0;
    end else begin
      m_digits.push_back(d);
      if (m_digits.size() == 3) begin
        n = m_digits[0] * 100 + m_digits[1] * 10 + m_digits[2];
        if (n > 255) model_error(2'd3);
        else begin
          m_value = n[7:0];
          m_fv = 1;
        end
      end
    end
  endtask

  task automatic slot(input logic [6:0] p);
    seg = p;
    strobe = 1'b1;
    @(posedge clk);
    #1;
    model_slot(p);
    strobe = 1'b0;
  endtask

  task automatic idle();
    strobe = 1'b0;
    seg = 7'($urandom_range(0, 127));
    @(posedge clk);
    #1;
    m_fv = 0;
    m_err = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    strobe = 1'b0;
    seg = BLANK;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 13'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs(), 13'd0);
    end
    rst_n = 1'b1;
    idle();
    checks++;
    if (obs() !== expv()) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_basic();
    int s[5] = '{10, 0, 4, 2, 10};
    for (int i = 0; i < 5; i++) begin
      slot(pat[s[i]]);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL basic slot%0d got=%h exp=%h", i, obs(), expv());
      end
      if (i == 3) begin
        checks++;
        if (value !== 8'd42 || frame_valid !== 1'b1 || locked !== 1'b1) begin
          failures++;
          $display("FAIL basic_42 got value=%0d fv=%b locked=%b exp value=42 fv=1 locked=1", value, frame_valid, locked);
        end
      end
    end
    idle();
    checks++;
    if (frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_single_pulse got=%b exp=0", frame_valid);
    end
  endtask

  task automatic test_overflow();
    int s[8] = '{2, 5, 5, 10, 2, 5, 6, 10};
    for (int i = 0; i < 8; i++) begin
      slot(pat[s[i]]);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL overflow slot%0d got=%h exp=%h", i, obs(), expv());
      end
      if (i == 2) begin
        checks++;
        if (value !== 8'd255 || frame_valid !== 1'b1) begin
          failures++;
          $display("FAIL overflow_255 got value=%0d fv=%b exp value=255 fv=1", value, frame_valid);
        end
      end
      if (i == 6) begin
        checks++;
        if (err !== 1'b1 || err_code !== 2'd3 || value !== 8'd255 || frame_valid !== 1'b0) begin
          failures++;
          $display("FAIL overflow_256 got err=%b code=%0d value=%0d fv=%b exp err=1 code=3 value=255 fv=0",
                   err, err_code, value, frame_valid);
        end
      end
    end
  endtask

  task automatic test_bad_pattern();
    logic [6:0] s[7];
    s = '{pat[1], 7'h7E, pat[10], pat[0], pat[0], pat[9], pat[10]};
    for (int i = 0; i < 7; i++) begin
      slot(s[i]);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL bad_pattern slot%0d got=%h exp=%h", i, obs(), expv());
      end
      if (i == 1) begin
        checks++;
        if (err !== 1'b1 || err_code !== 2'd1 || locked !== 1'b0) begin
          failures++;
          $display("FAIL bad_pattern_err got err=%b code=%0d locked=%b exp err=1 code=1 locked=0", err, err_code, locked);
        end
      end
    end
    checks++;
    if (value !== 8'd9) begin
      failures++;
      $display("FAIL bad_pattern_recover got=%0d exp=9", value);
    end
  endtask

  task automatic test_early_blank();
    int s[6] = '{1, 10, 1, 2, 3, 10};
    for (int i = 0; i < 6; i++) begin
      slot(pat[s[i]]);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL early_blank slot%0d got=%h exp=%h", i, obs(), expv());
      end
      if (i == 1) begin
        checks++;
        if (err !== 1'b1 || err_code !== 2'd2 || locked !== 1'b1) begin
          failures++;
          $display("FAIL early_blank_sync got err=%b code=%0d locked=%b exp err=1 code=2 locked=1", err, err_code, locked);
        end
      end
      if (i == 4) begin
        checks++;
        if (value !== 8'd123 || err !== 1'b0 || frame_valid !== 1'b1) begin
          failures++;
          $display("FAIL early_blank_123 got value=%0d err=%b fv=%b exp value=123 err=0 fv=1", value, err, frame_valid);
        end
      end
    end
  endtask

  task automatic test_missing_blank();
    int s[6] = '{1, 0, 5, 6, 7, 10};
    for (int i = 0; i < 6; i++) begin
      slot(pat[s[i]]);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL missing_blank slot%0d got=%h exp=%h", i, obs(), expv());
      end
      if (i == 3) begin
        checks++;
        if (err !== 1'b1 || err_code !== 2'd2 || locked !== 1'b0 || value !== 8'd105) begin
          failures++;
          $display("FAIL missing_blank_sync got err=%b code=%0d locked=%b value=%0d exp err=1 code=2 locked=0 value=105",
                   err, err_code, locked, value);
        end
      end
      if (i == 4) begin
        checks++;
        if (err !== 1'b0 || locked !== 1'b0) begin
          failures++;
          $display("FAIL missing_blank_hunt got err=%b locked=%b exp err=0 locked=0", err, locked);
        end
      end
    end
    // Overflowing frame followed by a non-blank: overflow error then sync error.
    slot(pat[3]); slot(pat[4]); slot(pat[5]);
    checks++;
    if (err !== 1'b1 || err_code !== 2'd3 || value !== 8'd105) begin
      failures++;
      $display("FAIL overflow_345 got err=%b code=%0d value=%0d exp err=1 code=3 value=105", err, err_code, value);
    end
    slot(pat[6]);
    checks++;
    if (err !== 1'b1 || err_code !== 2'd2 || locked !== 1'b0) begin
      failures++;
      $display("FAIL overflow_then_sync got err=%b code=%0d locked=%b exp err=1 code=2 locked=0", err, err_code, locked);
    end
  endtask

  task automatic test_async_reset();
    int s[5] = '{8, 10, 0, 0, 7};
    slot(pat[10]); slot(pat[1]); slot(pat[2]);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs() !== 13'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", obs(), 13'd0);
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      slot(pat[s[i]]);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL async_reset slot%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    checks++;
    if (value !== 8'd7 || frame_valid !== 1'b1) begin
      failures++;
      $display("FAIL async_reset_7 got value=%0d fv=%b exp value=7 fv=1", value, frame_valid);
    end
  endtask

  task automatic test_back_to_back();
    int frames = 0;
    for (int f = 0; f < 40; f++) begin
      slot(BLANK);
      slot(pat[$urandom_range(0, 2)]);
      slot(pat[$urandom_range(0, 9)]);
      slot(pat[$urandom_range(0, 9)]);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL back_to_back frame%0d got=%h exp=%h", f, obs(), expv());
      end
      if (m_fv) frames++;
    end
    checks++;
    if (frames < 10) begin
      failures++;
      $display("FAIL back_to_back_coverage got=%0d exp>=10", frames);
    end
  endtask

  task automatic test_random();
    logic [6:0] p;
    int r;
    for (int i = 0; i < 1200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 25) p = BLANK;
      else if (r < 35) p = 7'($urandom_range(0, 127));
      else if (r < 55) p = pat[$urandom_range(0, 2)];
      else p = pat[$urandom_range(0, 9)];
      if ($urandom_range(0, 3) == 0) begin
        idle();
        checks++;
        if (obs() !== expv()) begin
          failures++;
          $display("FAIL random_idle step%0d got=%h exp=%h", i, obs(), expv());
        end
      end
      slot(p);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL random step%0d seg=%h got=%h exp=%h", i, p, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_bad_pattern();
    test_early_blank();
    test_missing_blank();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
